// File: rtl/fdivsqrt_result_buffer.sv
// rtl/fdivsqrt_result_buffer.sv - two-entry FIFO decoupling divide/sqrt results from rounding/writeback
// Optional same-cycle bypass when empty: define FDIVSQRT_RESULT_BYPASS_EN.
module fdivsqrt_result_buffer #(
  parameter int QMW  = 66,
  parameter int QEW  = 13,
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [QMW-1:0]  QmIn,
  input  logic [QEW-1:0]  QeIn,
  input  logic            StickyIn,
  input  logic [XLEN-1:0] IntResIn,
  input  logic            IntOpIn,
  input  logic [TAGW-1:0] TagIn,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [QMW-1:0]  QmOut,
  output logic [QEW-1:0]  QeOut,
  output logic            StickyOut,
  output logic [XLEN-1:0] IntResOut,
  output logic            IntOpOut,
  output logic [TAGW-1:0] TagOut,
  output logic            DropErr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [QMW-1:0]  qm;
    logic [QEW-1:0]  qe;
    logic            sticky;
    logic [XLEN-1:0] int_res;
    logic            int_op;
    logic [TAGW-1:0] tag;
  } entry_t;

  state_e state_q, state_d;
  logic   rd_ptr_q, rd_ptr_d;
  logic   wr_ptr_q, wr_ptr_d;
  logic   drop_err_q, drop_err_d;
  entry_t ent_q [2];
  entry_t in_ent;
  entry_t head;
  logic   wr_en;
  logic   push, pop, push_store, bypass;

  assign in_ent = '{qm: QmIn, qe: QeIn, sticky: StickyIn, int_res: IntResIn,
                    int_op: IntOpIn, tag: TagIn};

  // InReady is purely registered so the divider's start gating never sees OutReady.
  assign InReady = (state_q != FULL);
  assign push    = InValid & InReady;

`ifdef FDIVSQRT_RESULT_BYPASS_EN
  // An empty buffer hands a result straight through when the consumer is ready.
  assign bypass = (state_q == EMPTY) & InValid & OutReady & ~Flush;
`else
  assign bypass = 1'b0;
`endif

  assign OutValid   = (state_q != EMPTY) | bypass;
  assign pop        = OutValid & OutReady;
  assign push_store = push & ~bypass;
  assign head       = bypass ? in_ent : ent_q[rd_ptr_q];

  assign QmOut     = head.qm;
  assign QeOut     = head.qe;
  assign StickyOut = head.sticky;
  assign IntResOut = head.int_res;
  assign IntOpOut  = head.int_op;
  assign TagOut    = head.tag;
  assign DropErr   = drop_err_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    drop_err_d = drop_err_q | (InValid & ~InReady & ~Flush);
    if (Flush) begin
      state_d  = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_store) begin
            state_d  = ONE;
            wr_en    = 1'b1;
            wr_ptr_d = ~wr_ptr_q;
          end
        end
        ONE: begin
          if (push_store) begin
            wr_en    = 1'b1;
            wr_ptr_d = ~wr_ptr_q;
          end
          if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
          end
          if (push_store && !pop) begin
            state_d = FULL;
          end else if (pop && !push_store) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d  = ONE;
            rd_ptr_d = ~rd_ptr_q;
          end
        end
        default: begin
          state_d  = EMPTY;
          rd_ptr_d = 1'b0;
          wr_ptr_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      drop_err_q <= drop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ent_q[i] <= '0;
      end
    end else if (wr_en) begin
      ent_q[wr_ptr_q] <= in_ent;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_result_buffer.sv
// tb/tb_fdivsqrt_result_buffer.sv - directed self-checking bench for fdivsqrt_result_buffer
// Expectations follow FDIVSQRT_RESULT_BYPASS_EN when the bench is built with it.
module tb_fdivsqrt_result_buffer;

  logic        clk = 1'b0;
  logic        reset, Flush, InValid, InReady;
  logic [65:0] QmIn, QmOut;
  logic [12:0] QeIn, QeOut;
  logic        StickyIn, StickyOut;
  logic [63:0] IntResIn, IntResOut;
  logic        IntOpIn, IntOpOut;
  logic [4:0]  TagIn, TagOut;
  logic        OutValid, OutReady, DropErr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fdivsqrt_result_buffer dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .QmIn(QmIn), .QeIn(QeIn), .StickyIn(StickyIn), .IntResIn(IntResIn),
    .IntOpIn(IntOpIn), .TagIn(TagIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .QmOut(QmOut), .QeOut(QeOut), .StickyOut(StickyOut), .IntResOut(IntResOut),
    .IntOpOut(IntOpOut), .TagOut(TagOut), .DropErr(DropErr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] t, input logic rdy);
    InValid  = v;
    TagIn    = t;
    OutReady = rdy;
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    QmIn = '0; QeIn = '0; StickyIn = 1'b0; IntResIn = '0; IntOpIn = 1'b0; TagIn = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("idle_outvalid", OutValid, 0);
    check("idle_inready", InReady, 1);
    check("idle_droperr", DropErr, 0);
    check("idle_qm", QmOut, 0);

    // single push with consumer ready
    QmIn = 66'h1_0000_0000_0000_0003; QeIn = 13'h3FF; StickyIn = 1'b1;
    IntResIn = 64'hDEAD_BEEF_0123_4567; IntOpIn = 1'b1;
    drive(1'b1, 5'd7, 1'b1);
    #1;
`ifdef FDIVSQRT_RESULT_BYPASS_EN
    check("byp_valid", OutValid, 1);
    check("byp_qm", QmOut, 66'h1_0000_0000_0000_0003);
    check("byp_tag", TagOut, 7);
    tick();
    InValid = 1'b0;
    #1;
    check("byp_empty_after", OutValid, 0);
`else
    check("push_not_yet_valid", OutValid, 0);
    tick();
    InValid = 1'b0;
    #1;
    check("single_valid", OutValid, 1);
    check("single_qm", QmOut, 66'h1_0000_0000_0000_0003);
    check("single_qe", QeOut, 13'h3FF);
    check("single_tag", TagOut, 7);
    check("single_sticky", StickyOut, 1);
    check("single_intres", IntResOut, 64'hDEAD_BEEF_0123_4567);
    check("single_intop", IntOpOut, 1);
    tick();
    check("single_empty_after", OutValid, 0);
`endif
    StickyIn = 1'b0; IntOpIn = 1'b0;

    // fill with tags 1, 2 while consumer stalled
    drive(1'b1, 5'd1, 1'b0); tick();
    drive(1'b1, 5'd2, 1'b0); tick();
    InValid = 1'b0; #1;
    check("full_inready", InReady, 0);
    check("full_head", TagOut, 1);

    // push while full is dropped and flagged
    drive(1'b1, 5'd3, 1'b0);
    tick();
    InValid = 1'b0; #1;
    check("drop_flag", DropErr, 1);
    check("drop_head_stable", TagOut, 1);
    check("drop_outvalid_stable", OutValid, 1);

    OutReady = 1'b1; tick();
    check("pop1_tag", TagOut, 2);
    check("pop1_inready", InReady, 1);
    tick();
    OutReady = 1'b0; #1;
    check("drain_empty", OutValid, 0);
    check("drop_held", DropErr, 1);

    // ONE with simultaneous push and pop
    drive(1'b1, 5'd8, 1'b0); tick();
    check("one_head", TagOut, 8);
    drive(1'b1, 5'd4, 1'b1); tick();
    drive(1'b0, 5'd0, 1'b0); #1;
    check("pushpop_tag", TagOut, 4);
    check("pushpop_one_ready", InReady, 1);
    check("pushpop_one_valid", OutValid, 1);
    OutReady = 1'b1; tick();
    OutReady = 1'b0; #1;
    check("pushpop_drain", OutValid, 0);

    // five back-to-back transactions across pointer wrap
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(10 + i), 1'b1);
`ifdef FDIVSQRT_RESULT_BYPASS_EN
      #1;
      check($sformatf("wrap_tag%0d", i), TagOut, 10 + i);
      tick();
`else
      tick();
      check($sformatf("wrap_tag%0d", i), TagOut, 10 + i);
      check($sformatf("wrap_valid%0d", i), OutValid, 1);
`endif
    end
    InValid = 1'b0; tick();
    OutReady = 1'b0; #1;
    check("wrap_drain", OutValid, 0);

    // flush in FULL with a same-cycle push
    drive(1'b1, 5'd20, 1'b0); tick();
    drive(1'b1, 5'd21, 1'b0); tick();
    InValid = 1'b0; #1;
    check("pre_flush_full", InReady, 0);
    Flush = 1'b1; drive(1'b1, 5'd9, 1'b0);
    tick();
    Flush = 1'b0; InValid = 1'b0; #1;
    check("flush_outvalid", OutValid, 0);
    check("flush_inready", InReady, 1);
    check("flush_keeps_droperr", DropErr, 1);
    drive(1'b1, 5'd22, 1'b0); tick();
    InValid = 1'b0; #1;
    check("post_flush_head", TagOut, 22);

    // reset from FULL
    drive(1'b1, 5'd23, 1'b0); tick();
    InValid = 1'b0; #1;
    check("refill_full", InReady, 0);
    reset = 1'b1; tick();
    reset = 1'b0; #1;
    check("rst_outvalid", OutValid, 0);
    check("rst_inready", InReady, 1);
    check("rst_droperr", DropErr, 0);
    check("rst_qm", QmOut, 0);
    check("rst_tag", TagOut, 0);
    check("rst_intres", IntResOut, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
